// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the M-mode trap controller: CSR addresses, cause codes,
// mstatus bit positions and FSM state encodings.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [4:0] EXC_INST_MIS = 5'd0;
  localparam logic [4:0] EXC_ILLEGAL  = 5'd2;
  localparam logic [4:0] EXC_EBREAK   = 5'd3;
  localparam logic [4:0] EXC_LD_MIS   = 5'd4;
  localparam logic [4:0] EXC_ST_MIS   = 5'd6;
  localparam logic [4:0] EXC_ECALL    = 5'd11;

  localparam int IRQ_MSI        = 3;
  localparam int IRQ_MTI        = 7;
  localparam int IRQ_MEI        = 11;
  localparam int IRQ_LOCAL_BASE = 16;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

endpackage

// File: rtl/trap_ctrl_if.sv
// Write-back / fetch side bundle of the trap controller; master is the pipeline,
// slave is trap_ctrl.
interface trap_ctrl_if #(
  parameter int XLEN          = 32,
  parameter int NUM_LOCAL_IRQ = 4
);
  logic                     retire_valid_i;
  logic [XLEN-1:0]          pc_i;
  logic [31:0]              instruction_i;
  logic [XLEN-1:0]          mem_addr_i;
  logic                     e_inst_addr_mis_i;
  logic                     e_illegal_inst_i;
  logic                     e_ecall_i;
  logic                     e_ebreak_i;
  logic                     e_ld_addr_mis_i;
  logic                     e_st_addr_mis_i;
  logic                     mret_i;
  logic [2:0]               irq_m_i;
  logic [NUM_LOCAL_IRQ-1:0] irq_local_i;
  logic                     csr_we_i;
  logic [11:0]              csr_addr_i;
  logic [XLEN-1:0]          csr_wdata_i;
  logic [XLEN-1:0]          csr_rdata_o;
  logic                     kill_o;
  logic                     stall_o;
  logic                     flush_o;
  logic                     redirect_valid_o;
  logic [XLEN-1:0]          redirect_pc_o;
  logic                     redirect_ready_i;

  modport master (
    output retire_valid_i, pc_i, instruction_i, mem_addr_i,
           e_inst_addr_mis_i, e_illegal_inst_i, e_ecall_i, e_ebreak_i,
           e_ld_addr_mis_i, e_st_addr_mis_i, mret_i, irq_m_i, irq_local_i,
           csr_we_i, csr_addr_i, csr_wdata_i, redirect_ready_i,
    input  csr_rdata_o, kill_o, stall_o, flush_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    input  retire_valid_i, pc_i, instruction_i, mem_addr_i,
           e_inst_addr_mis_i, e_illegal_inst_i, e_ecall_i, e_ebreak_i,
           e_ld_addr_mis_i, e_st_addr_mis_i, mret_i, irq_m_i, irq_local_i,
           csr_we_i, csr_addr_i, csr_wdata_i, redirect_ready_i,
    output csr_rdata_o, kill_o, stall_o, flush_o, redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop synchroniser for asynchronous interrupt levels; STAGES cycles of
// latency, STAGES = 0 passes the inputs straight through. No backpressure.
module irq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [STAGES];
      logic [WIDTH-1:0] sync_d [STAGES];

      always_comb begin
        sync_d[0] = d_i;
        for (int i = 1; i < STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk_i) begin
        for (int i = 0; i < STAGES; i++) begin
          if (rst_i) sync_q[i] <= '0;
          else       sync_q[i] <= sync_d[i];
        end
      end

      assign q_o = sync_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/trap_ctrl.sv
// M-mode trap controller: decides trap/mret combinationally in WB (kill_o same cycle),
// then FLUSH for one cycle and REDIRECT held until fetch accepts.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int              XLEN          = 32,
  parameter int              NUM_LOCAL_IRQ = 4,
  parameter int              SYNC_STAGES   = 2,
  parameter logic [XLEN-1:0] MTVEC_RESET   = '0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  trap_ctrl_if.slave bus
);

  localparam int NIRQ = 3 + NUM_LOCAL_IRQ;

  logic [NIRQ-1:0] irq_raw;
  logic [NIRQ-1:0] irq_lvl;

  assign irq_raw = {bus.irq_local_i, bus.irq_m_i};

  irq_sync #(
    .WIDTH  (NIRQ),
    .STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (irq_raw),
    .q_o   (irq_lvl)
  );

  logic [1:0]      state_q, state_d;
  logic            mie_bit_q, mie_bit_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] irq_mask;
  logic [XLEN-1:0] irq_pend;
  logic [4:0]      irq_code;
  logic [4:0]      exc_code;
  logic [XLEN-1:0] exc_tval;
  logic [4:0]      trap_code;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] mtvec_base;
  logic            retire, exc_any, take_irq, take_exc, trap, do_mret, csr_wr;

  always_comb begin
    mip      = '0;
    irq_mask = '0;
    mip[IRQ_MSI] = irq_lvl[0];
    mip[IRQ_MTI] = irq_lvl[1];
    mip[IRQ_MEI] = irq_lvl[2];
    irq_mask[IRQ_MSI] = 1'b1;
    irq_mask[IRQ_MTI] = 1'b1;
    irq_mask[IRQ_MEI] = 1'b1;
    for (int k = 0; k < NUM_LOCAL_IRQ; k++) begin
      mip[IRQ_LOCAL_BASE+k]      = irq_lvl[3+k];
      irq_mask[IRQ_LOCAL_BASE+k] = 1'b1;
    end
  end

  // Interrupt arbitration: later assignments win, so MEI > MSI > MTI > lowest local.
  always_comb begin
    irq_pend = mip & mie_q;
    irq_code = '0;
    for (int k = NUM_LOCAL_IRQ - 1; k >= 0; k--) begin
      if (irq_pend[IRQ_LOCAL_BASE+k]) irq_code = 5'(IRQ_LOCAL_BASE + k);
    end
    if (irq_pend[IRQ_MTI]) irq_code = 5'(IRQ_MTI);
    if (irq_pend[IRQ_MSI]) irq_code = 5'(IRQ_MSI);
    if (irq_pend[IRQ_MEI]) irq_code = 5'(IRQ_MEI);
  end

  always_comb begin
    exc_code = '0;
    exc_tval = '0;
    if (bus.e_inst_addr_mis_i) begin
      exc_code = EXC_INST_MIS;
      exc_tval = bus.pc_i;
    end else if (bus.e_illegal_inst_i) begin
      exc_code = EXC_ILLEGAL;
      exc_tval = XLEN'(bus.instruction_i);
    end else if (bus.e_ebreak_i) begin
      exc_code = EXC_EBREAK;
      exc_tval = bus.pc_i;
    end else if (bus.e_ecall_i) begin
      exc_code = EXC_ECALL;
    end else if (bus.e_ld_addr_mis_i) begin
      exc_code = EXC_LD_MIS;
      exc_tval = bus.mem_addr_i;
    end else if (bus.e_st_addr_mis_i) begin
      exc_code = EXC_ST_MIS;
      exc_tval = bus.mem_addr_i;
    end
  end

  assign retire   = (state_q == ST_RUN) && !rst_i && bus.retire_valid_i;
  assign exc_any  = bus.e_inst_addr_mis_i | bus.e_illegal_inst_i | bus.e_ecall_i |
                    bus.e_ebreak_i | bus.e_ld_addr_mis_i | bus.e_st_addr_mis_i;
  assign take_irq = retire && mie_bit_q && (|irq_pend);
  assign take_exc = retire && !take_irq && exc_any;
  assign trap     = take_irq || take_exc;
  assign do_mret  = retire && bus.mret_i && !trap;
  assign csr_wr   = retire && bus.csr_we_i && !trap;

  assign trap_code   = take_irq ? irq_code : exc_code;
  assign mtvec_base  = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_target = (take_irq && mtvec_q[1:0] == 2'b01)
                     ? mtvec_base + (XLEN'(trap_code) << 2)
                     : mtvec_base;

  always_comb begin
    bus.csr_rdata_o = '0;
    case (bus.csr_addr_i)
      CSR_MSTATUS: begin
        bus.csr_rdata_o[MSTATUS_MIE]  = mie_bit_q;
        bus.csr_rdata_o[MSTATUS_MPIE] = mpie_q;
        bus.csr_rdata_o[12:11]        = 2'b11;
      end
      CSR_MIE:      bus.csr_rdata_o = mie_q;
      CSR_MTVEC:    bus.csr_rdata_o = mtvec_q;
      CSR_MSCRATCH: bus.csr_rdata_o = mscratch_q;
      CSR_MEPC:     bus.csr_rdata_o = mepc_q;
      CSR_MCAUSE:   bus.csr_rdata_o = mcause_q;
      CSR_MTVAL:    bus.csr_rdata_o = mtval_q;
      CSR_MIP:      bus.csr_rdata_o = mip;
      default:      bus.csr_rdata_o = '0;
    endcase
  end

  always_comb begin
    mie_bit_d     = mie_bit_q;
    mpie_d        = mpie_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    redirect_pc_d = redirect_pc_q;

    if (csr_wr) begin
      case (bus.csr_addr_i)
        CSR_MSTATUS: begin
          mie_bit_d = bus.csr_wdata_i[MSTATUS_MIE];
          mpie_d    = bus.csr_wdata_i[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = bus.csr_wdata_i & irq_mask;
        CSR_MTVEC:    mtvec_d    = {bus.csr_wdata_i[XLEN-1:2],
                                    (bus.csr_wdata_i[1:0] == 2'b01) ? 2'b01 : 2'b00};
        CSR_MSCRATCH: mscratch_d = bus.csr_wdata_i;
        CSR_MEPC:     mepc_d     = {bus.csr_wdata_i[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = bus.csr_wdata_i;
        CSR_MTVAL:    mtval_d    = bus.csr_wdata_i;
        default: ;
      endcase
    end

    if (trap) begin
      mepc_d        = {bus.pc_i[XLEN-1:2], 2'b00};
      mcause_d      = {take_irq, (XLEN-1)'(trap_code)};
      mtval_d       = take_irq ? '0 : exc_tval;
      mpie_d        = mie_bit_q;
      mie_bit_d     = 1'b0;
      redirect_pc_d = trap_target;
    end else if (do_mret) begin
      mie_bit_d     = mpie_q;
      mpie_d        = 1'b1;
      redirect_pc_d = mepc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (trap || do_mret) state_d = ST_FLUSH;
      ST_FLUSH:    state_d = ST_REDIRECT;
      ST_REDIRECT: if (bus.redirect_ready_i) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      mie_bit_q     <= 1'b0;
      mpie_q        <= 1'b0;
      mie_q         <= '0;
      mtvec_q       <= MTVEC_RESET;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      mie_bit_q     <= mie_bit_d;
      mpie_q        <= mpie_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.kill_o           = trap;
  assign bus.stall_o          = (state_q != ST_RUN);
  assign bus.flush_o          = (state_q == ST_FLUSH);
  assign bus.redirect_valid_o = (state_q == ST_REDIRECT);
  assign bus.redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception table plus hand sequences for
// vectored interrupts, priority, mret backpressure and reset during REDIRECT.
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(32), .NUM_LOCAL_IRQ(4)) bus ();

  trap_ctrl #(
    .XLEN          (32),
    .NUM_LOCAL_IRQ (4),
    .SYNC_STAGES   (2),
    .MTVEC_RESET   (32'h0000_0000)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [5:0]  exc;   // {inst_mis, illegal, ebreak, ecall, ld_mis, st_mis}
    logic        csr_we;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] maddr;
    logic        trap;
    logic [31:0] cause;
    logic [31:0] tval;
    logic [31:0] mepc;
    logic [31:0] mscratch;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    bus.retire_valid_i    = 1'b0;
    bus.pc_i              = '0;
    bus.instruction_i     = '0;
    bus.mem_addr_i        = '0;
    bus.e_inst_addr_mis_i = 1'b0;
    bus.e_illegal_inst_i  = 1'b0;
    bus.e_ecall_i         = 1'b0;
    bus.e_ebreak_i        = 1'b0;
    bus.e_ld_addr_mis_i   = 1'b0;
    bus.e_st_addr_mis_i   = 1'b0;
    bus.mret_i            = 1'b0;
    bus.csr_we_i          = 1'b0;
    bus.csr_wdata_i       = '0;
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    clear_in();
    bus.retire_valid_i = 1'b1;
    bus.csr_we_i       = 1'b1;
    bus.csr_addr_i     = addr;
    bus.csr_wdata_i    = data;
    @(negedge clk);
    clear_in();
  endtask

  task automatic csr_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    @(negedge clk);
    bus.csr_addr_i = addr;
    #1;
    chk(name, bus.csr_rdata_o, exp);
  endtask

  // Called at the negedge just after the trapping/mret retire cycle.
  task automatic expect_redirect(input string name, input logic [31:0] target);
    @(negedge clk);
    clear_in();
    #1;
    chk({name, " flush"}, 32'(bus.flush_o), 32'd1);
    chk({name, " stall"}, 32'(bus.stall_o), 32'd1);
    @(negedge clk);
    #1;
    chk({name, " redirect_valid"}, 32'(bus.redirect_valid_o), 32'd1);
    chk({name, " redirect_pc"}, bus.redirect_pc_o, target);
    @(negedge clk);
    #1;
    chk({name, " back to run"}, {30'd0, bus.redirect_valid_o, bus.stall_o}, 32'd0);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    string nm;
    v  = vecs[idx];
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    clear_in();
    bus.retire_valid_i    = 1'b1;
    bus.pc_i              = v.pc;
    bus.instruction_i     = v.instr;
    bus.mem_addr_i        = v.maddr;
    bus.e_inst_addr_mis_i = v.exc[5];
    bus.e_illegal_inst_i  = v.exc[4];
    bus.e_ebreak_i        = v.exc[3];
    bus.e_ecall_i         = v.exc[2];
    bus.e_ld_addr_mis_i   = v.exc[1];
    bus.e_st_addr_mis_i   = v.exc[0];
    bus.csr_we_i          = v.csr_we;
    bus.csr_addr_i        = 12'h340;
    bus.csr_wdata_i       = v.wdata;
    #1;
    chk({nm, " kill"}, 32'(bus.kill_o), 32'(v.trap));
    if (v.trap) begin
      expect_redirect(nm, 32'h0000_0200);
      csr_chk({nm, " mcause"}, 12'h342, v.cause);
      csr_chk({nm, " mtval"}, 12'h343, v.tval);
      csr_chk({nm, " mepc"}, 12'h341, v.mepc);
    end else begin
      @(negedge clk);
      clear_in();
      #1;
      chk({nm, " no flush"}, {30'd0, bus.flush_o, bus.stall_o}, 32'd0);
    end
    csr_chk({nm, " mscratch"}, 12'h340, v.mscratch);
  endtask

  initial begin
    vecs[0] = '{6'b000000, 1'b1, 32'h55,   32'h0F0, 32'h13,        32'h0,    1'b0, 32'd0,  32'h0,         32'h0,   32'h55};
    vecs[1] = '{6'b010000, 1'b0, 32'h0,    32'h100, 32'hFFFF_FFFF, 32'h0,    1'b1, 32'd2,  32'hFFFF_FFFF, 32'h100, 32'h55};
    vecs[2] = '{6'b110000, 1'b0, 32'h0,    32'h102, 32'h13,        32'h0,    1'b1, 32'd0,  32'h102,       32'h100, 32'h55};
    vecs[3] = '{6'b001100, 1'b0, 32'h0,    32'h140, 32'h13,        32'h0,    1'b1, 32'd3,  32'h140,       32'h140, 32'h55};
    vecs[4] = '{6'b000110, 1'b0, 32'h0,    32'h144, 32'h13,        32'h1003, 1'b1, 32'd11, 32'h0,         32'h144, 32'h55};
    vecs[5] = '{6'b000010, 1'b0, 32'h0,    32'h148, 32'h13,        32'h1003, 1'b1, 32'd4,  32'h1003,      32'h148, 32'h55};
    vecs[6] = '{6'b000001, 1'b0, 32'h0,    32'h14C, 32'h13,        32'h2002, 1'b1, 32'd6,  32'h2002,      32'h14C, 32'h55};
    vecs[7] = '{6'b010010, 1'b0, 32'h0,    32'h150, 32'h1234_5677, 32'h3001, 1'b1, 32'd2,  32'h1234_5677, 32'h150, 32'h55};
    vecs[8] = '{6'b000100, 1'b1, 32'hDEAD, 32'h154, 32'h73,        32'h0,    1'b1, 32'd11, 32'h0,         32'h154, 32'h55};

    clear_in();
    bus.csr_addr_i       = '0;
    bus.irq_m_i          = '0;
    bus.irq_local_i      = '0;
    bus.redirect_ready_i = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset outputs", {28'd0, bus.kill_o, bus.stall_o, bus.flush_o, bus.redirect_valid_o}, 32'd0);
    chk("reset redirect_pc", bus.redirect_pc_o, 32'd0);
    csr_chk("reset mstatus", 12'h300, 32'h0000_1800);
    csr_chk("reset mtvec", 12'h305, 32'h0);
    csr_chk("unmapped read", 12'h7C0, 32'h0);

    csr_wr(12'h305, 32'h0000_0202);
    csr_chk("mtvec mode2 cleared", 12'h305, 32'h0000_0200);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Vectored timer interrupt through the 2-stage synchroniser.
    csr_wr(12'h305, 32'h0000_0201);
    csr_wr(12'h304, 32'h0000_0080);
    csr_wr(12'h300, 32'h0000_0008);
    csr_chk("mstatus MIE set", 12'h300, 32'h0000_1808);
    @(negedge clk);
    bus.irq_m_i = 3'b010;
    csr_chk("mip after 1 cycle", 12'h344, 32'h0);
    csr_chk("mip after 2 cycles", 12'h344, 32'h0000_0080);
    @(negedge clk);
    clear_in();
    bus.retire_valid_i = 1'b1;
    bus.pc_i           = 32'h300;
    #1;
    chk("mti kill", 32'(bus.kill_o), 32'd1);
    bus.irq_m_i = 3'b000;
    expect_redirect("mti", 32'h0000_021C);
    csr_chk("mti mcause", 12'h342, 32'h8000_0007);
    csr_chk("mti mtval", 12'h343, 32'h0);
    csr_chk("mti mepc", 12'h341, 32'h300);
    csr_chk("mti mstatus", 12'h300, 32'h0000_1880);

    // mret with fetch backpressure.
    csr_wr(12'h341, 32'h0000_0080);
    csr_chk("mip cleared", 12'h344, 32'h0);
    @(negedge clk);
    clear_in();
    bus.retire_valid_i   = 1'b1;
    bus.mret_i           = 1'b1;
    bus.redirect_ready_i = 1'b0;
    #1;
    chk("mret kill", 32'(bus.kill_o), 32'd0);
    @(negedge clk);
    clear_in();
    #1;
    chk("mret flush", 32'(bus.flush_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mret hold valid %0d", i), 32'(bus.redirect_valid_o), 32'd1);
      chk($sformatf("mret hold pc %0d", i), bus.redirect_pc_o, 32'h80);
    end
    bus.redirect_ready_i = 1'b1;
    @(negedge clk);
    #1;
    chk("mret accepted", 32'(bus.redirect_valid_o), 32'd0);
    csr_chk("mret mstatus", 12'h300, 32'h0000_1888);

    // MEI, MSI and local0 together, with an illegal instruction underneath.
    csr_wr(12'h304, 32'h0001_0808);
    @(negedge clk);
    bus.irq_m_i     = 3'b101;
    bus.irq_local_i = 4'b0001;
    @(negedge clk);
    csr_chk("mip three pending", 12'h344, 32'h0001_0808);
    @(negedge clk);
    clear_in();
    bus.retire_valid_i   = 1'b1;
    bus.pc_i             = 32'h400;
    bus.instruction_i    = 32'hFFFF_FFFF;
    bus.e_illegal_inst_i = 1'b1;
    #1;
    chk("prio kill", 32'(bus.kill_o), 32'd1);
    bus.irq_m_i     = 3'b000;
    bus.irq_local_i = 4'b0000;
    expect_redirect("prio", 32'h0000_022C);
    csr_chk("prio mcause", 12'h342, 32'h8000_000B);
    csr_chk("prio mtval", 12'h343, 32'h0);

    // Reset while REDIRECT is waiting on fetch.
    @(negedge clk);
    clear_in();
    bus.retire_valid_i   = 1'b1;
    bus.pc_i             = 32'h500;
    bus.e_illegal_inst_i = 1'b1;
    bus.redirect_ready_i = 1'b0;
    @(negedge clk);
    clear_in();
    @(negedge clk);
    #1;
    chk("pre-reset redirect_valid", 32'(bus.redirect_valid_o), 32'd1);
    rst                  = 1'b1;
    bus.retire_valid_i   = 1'b1;
    bus.e_illegal_inst_i = 1'b1;
    @(negedge clk);
    #1;
    chk("rst redirect dropped", {29'd0, bus.redirect_valid_o, bus.stall_o, bus.flush_o}, 32'd0);
    chk("rst redirect_pc", bus.redirect_pc_o, 32'd0);
    chk("kill held low in rst", 32'(bus.kill_o), 32'd0);
    @(negedge clk);
    clear_in();
    bus.redirect_ready_i = 1'b1;
    rst = 1'b0;
    csr_chk("rst mstatus", 12'h300, 32'h0000_1800);
    csr_chk("rst mie", 12'h304, 32'h0);
    csr_chk("rst mtvec", 12'h305, 32'h0);
    csr_chk("rst mscratch", 12'h340, 32'h0);
    csr_chk("rst mepc", 12'h341, 32'h0);
    csr_chk("rst mcause", 12'h342, 32'h0);
    csr_chk("rst mtval", 12'h343, 32'h0);
    csr_chk("rst mip", 12'h344, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
